l1_bus_scheduler: RTL and testbench
===================================

L1_BUS_SCHEDULER -- requirements
Module: l1_bus_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4; number of L1 requesters (0=DCACHE, 1=DMMU, 2=ICACHE, 3=IMMU).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4; maximum read requests in flight, range 1..7.
REQ-003 SHALL have the following ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_addr  in  NUM_REQ*32  word-aligned request address.
- req_rnw  in  NUM_REQ  1=read, 0=write.
- req_len  in  NUM_REQ*2  burst length minus 1 (0..3 words).
- req_ready  out  NUM_REQ  one-hot request accept.
- wr_valid, wr_data  in  NUM_REQ, NUM_REQ*32  write beats.
- wr_ready  out  NUM_REQ  write beat accept.
- mem_req_valid  out  1  registered downstream request.
- mem_req_ready  in  1.
- mem_addr, mem_rnw, mem_len, mem_id  out  32, 1, 2, 2  downstream request fields; mem_id is the requester index.
- mem_wr_valid, mem_wr_data  out  1, 32.
- mem_wr_ready  in  1.
- mem_rd_valid, mem_rd_data, mem_rd_id, mem_rd_last  in  1, 32, 2, 1  read return.
- rd_valid  out  NUM_REQ  one-hot routed read beat.
- rd_data, rd_last  out  32, 1  shared read data and last flag.

Function
REQ-004 SHALL implement states IDLE, REQ (output register full), WDATA (write burst forwarding).
REQ-005 SHALL, in IDLE, grant exactly one asserted req_valid by round-robin, starting the search at rr_ptr.
REQ-006 SHALL block grants when the winner is a read and outstanding == MAX_OUTSTANDING; writes are not blocked by this limit.
REQ-007 SHALL drive req_ready combinationally, only to the winner, only in IDLE.
REQ-008 SHALL register addr/rnw/len/id on the accept cycle, assert mem_req_valid the next cycle (1-cycle latency), and enter REQ.
REQ-009 SHALL set rr_ptr to (winner+1) mod NUM_REQ on each grant.
REQ-010 SHALL hold all mem_req_* fields stable while mem_req_valid && !mem_req_ready.
REQ-011 SHALL, on the mem_req handshake, go REQ->IDLE for a read and REQ->WDATA for a write; it SHALL load a beat counter with mem_len.
REQ-012 SHALL, in WDATA, pass wr_valid/wr_data of the latched requester to mem_wr_* and mem_wr_ready back to its wr_ready, combinationally; all other wr_ready SHALL be 0.
REQ-013 SHALL decrement the beat counter on each write beat handshake and return to IDLE after the handshake at count 0; no grants in WDATA.
REQ-014 SHALL keep an outstanding counter: +1 on a read mem_req handshake, -1 on mem_rd_valid && mem_rd_last, unchanged when both occur in the same cycle.
REQ-015 SHALL route read returns combinationally: rd_valid[mem_rd_id] = mem_rd_valid, rd_data = mem_rd_data, rd_last = mem_rd_last; return data has no backpressure.
REQ-016 SHALL ignore mem_rd_valid when outstanding == 0 (no decrement, no underflow); the counter SHALL never exceed MAX_OUTSTANDING.
REQ-017 SHALL leave requests that are not granted pending, unchanged; dropping req_valid before grant is legal.

Reset
REQ-018 SHALL, when rst_n is sampled low, force state=IDLE, rr_ptr=0, outstanding=0, beat counter=0, mem_req_valid=0, and the registered request fields to 0.
REQ-019 SHALL abandon an in-progress burst or request on reset; reset takes priority over every other event in that cycle.
REQ-020 SHALL drive req_ready, wr_ready, mem_wr_valid and rd_valid to 0 while rst_n is low.

Configuration
REQ-021 SHALL support macro L1_SCHED_DCACHE_PRIORITY_EN: when defined, requester 0 wins whenever req_valid[0] is set and is eligible, and rr_ptr is not updated for that grant.
REQ-022 SHALL, without L1_SCHED_DCACHE_PRIORITY_EN, use pure round-robin across all requesters.

Verification
REQ-023 SHALL cover: all 4 req_valid held high, reads, mem_req_ready=1 -> grant order 0,1,2,3,0, each mem_req_valid 1 cycle after its req_ready.
REQ-024 SHALL cover: write from requester 2 with len=3, mem_wr_ready toggling -> exactly 4 beats forwarded in order, and no grant until the 4th beat handshake.
REQ-025 SHALL cover: 4 reads issued with MAX_OUTSTANDING=4 and no returns -> 5th read blocked; a pending write is still granted; one mem_rd_last return unblocks the read.
REQ-026 SHALL cover: read request handshake and mem_rd_last return in the same cycle at outstanding=2 -> counter stays 2.
REQ-027 SHALL cover: rst_n low mid-WDATA (beat 2 of 4) -> next cycle IDLE, mem_req_valid=0, all wr_ready=0, outstanding=0.
REQ-028 SHALL cover: macro defined, req_valid=4'b1111 held -> requester 0 granted every eligible cycle; macro undefined -> round-robin as in REQ-023.

Source files
------------

// File: rtl/l1_bus_scheduler.sv
// l1_bus_scheduler
//   Arbitrates the L1 requesters (0=DCACHE, 1=DMMU, 2=ICACHE, 3=IMMU) onto one
//   downstream memory request channel. Grants use round-robin. Write bursts are
//   forwarded beat by beat from the granted requester. Read returns are routed
//   back by id. The number of reads in flight is capped at MAX_OUTSTANDING.
//
//   Optional feature macro: L1_SCHED_DCACHE_PRIORITY_EN
//     When defined, requester 0 wins any cycle it is eligible, and that grant
//     leaves the round-robin pointer untouched.
//
// Ports
//   clk, rst_n                     clock; synchronous active-low reset
//   req_valid/addr/rnw/len         per-requester request (len = beats - 1)
//   req_ready                      one-hot accept, combinational, IDLE only
//   wr_valid/wr_data/wr_ready      per-requester write beats
//   mem_req_valid/ready            registered downstream request handshake
//   mem_addr/rnw/len/id            downstream request fields (id = requester)
//   mem_wr_valid/data/ready        forwarded write beats
//   mem_rd_valid/data/id/last      read return from memory
//   rd_valid/rd_data/rd_last       routed read return (one-hot valid)
//
//   Requester ids are 2 bits wide, so NUM_REQ must be in 1..4.
module l1_bus_scheduler #(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*32-1:0] req_addr,
   input  logic [NUM_REQ-1:0]    req_rnw,
   input  logic [NUM_REQ*2-1:0]  req_len,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ-1:0]    wr_valid,
   input  logic [NUM_REQ*32-1:0] wr_data,
   output logic [NUM_REQ-1:0]    wr_ready,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [31:0]           mem_addr,
   output logic                  mem_rnw,
   output logic [1:0]            mem_len,
   output logic [1:0]            mem_id,
   output logic                  mem_wr_valid,
   output logic [31:0]           mem_wr_data,
   input  logic                  mem_wr_ready,
   input  logic                  mem_rd_valid,
   input  logic [31:0]           mem_rd_data,
   input  logic [1:0]            mem_rd_id,
   input  logic                  mem_rd_last,
   output logic [NUM_REQ-1:0]    rd_valid,
   output logic [31:0]           rd_data,
   output logic                  rd_last
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WDATA = 2'd2
   } state_t;

   state_t             state_r, state_nxt_s;
   logic [1:0]         rr_ptr_r;
   logic [2:0]         outst_r;
   logic [1:0]         beat_cnt_r;
   logic               mem_req_valid_r;
   logic [31:0]        mem_addr_r;
   logic               mem_rnw_r;
   logic [1:0]         mem_len_r;
   logic [1:0]         mem_id_r;

   logic [NUM_REQ-1:0] eligible_s;
   logic               rd_room_s;
   logic               grant_found_s;
   logic               pri_grant_s;
   logic [1:0]         winner_s;
   logic [1:0]         scan_idx_s;
   logic               accept_s;
   logic [31:0]        win_addr_s;
   logic               win_rnw_s;
   logic [1:0]         win_len_s;
   logic               sel_wr_valid_s;
   logic [31:0]        sel_wr_data_s;
   logic               req_hs_s;
   logic               wr_hs_s;
   logic               rd_inc_s;
   logic               rd_dec_s;

   // A read is only eligible while there is room for one more read in flight;
   // writes stay eligible so they can get past a saturated read stream.
   always_comb begin
      rd_room_s = (outst_r < 3'(MAX_OUTSTANDING));
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible_s[i] = req_valid[i] & (~req_rnw[i] | rd_room_s);
      end
   end

   // Round-robin search among eligible requesters starting at rr_ptr.
   always_comb begin
      grant_found_s = 1'b0;
      winner_s      = 2'd0;
      pri_grant_s   = 1'b0;
      scan_idx_s    = 2'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx_s = 2'((int'(rr_ptr_r) + i) % NUM_REQ);
         if (!grant_found_s && eligible_s[scan_idx_s]) begin
            grant_found_s = 1'b1;
            winner_s      = scan_idx_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
`ifdef L1_SCHED_DCACHE_PRIORITY_EN
      if (eligible_s[0]) begin
         grant_found_s = 1'b1;
         winner_s      = 2'd0;
         pri_grant_s   = 1'b1;
      end else begin
         pri_grant_s   = 1'b0;
      end
`endif
   end

   // Winner request fields, and the latched requester's write beat.
   always_comb begin
      win_addr_s     = 32'd0;
      win_rnw_s      = 1'b0;
      win_len_s      = 2'd0;
      sel_wr_valid_s = 1'b0;
      sel_wr_data_s  = 32'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_addr_s     = (winner_s == 2'(i)) ? req_addr[i*32 +: 32] : win_addr_s;
         win_rnw_s      = (winner_s == 2'(i)) ? req_rnw[i]           : win_rnw_s;
         win_len_s      = (winner_s == 2'(i)) ? req_len[i*2 +: 2]    : win_len_s;
         sel_wr_valid_s = (mem_id_r == 2'(i)) ? wr_valid[i]          : sel_wr_valid_s;
         sel_wr_data_s  = (mem_id_r == 2'(i)) ? wr_data[i*32 +: 32]  : sel_wr_data_s;
      end
   end

   // Handshake-side outputs; all valids/readies are forced low during reset.
   always_comb begin
      accept_s     = (state_r == IDLE) && grant_found_s;
      req_ready    = {NUM_REQ{1'b0}};
      wr_ready     = {NUM_REQ{1'b0}};
      rd_valid     = {NUM_REQ{1'b0}};
      mem_wr_valid = rst_n && (state_r == WDATA) && sel_wr_valid_s;
      mem_wr_data  = sel_wr_data_s;
      rd_data      = mem_rd_data;
      rd_last      = mem_rd_last;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = rst_n & accept_s & (winner_s == 2'(i));
         wr_ready[i]  = rst_n & (state_r == WDATA) & (mem_id_r == 2'(i)) & mem_wr_ready;
         rd_valid[i]  = rst_n & mem_rd_valid & (mem_rd_id == 2'(i));
      end
      req_hs_s = mem_req_valid_r && mem_req_ready;
      wr_hs_s  = mem_wr_valid && mem_wr_ready;
      rd_inc_s = req_hs_s && mem_rnw_r;
      // Returns with nothing outstanding must not underflow the counter.
      rd_dec_s = mem_rd_valid && mem_rd_last && (outst_r != 3'd0);
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = REQ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         REQ: begin
            if (req_hs_s) begin
               state_nxt_s = mem_rnw_r ? IDLE : WDATA;
            end else begin
               state_nxt_s = REQ;
            end
         end
         WDATA: begin
            if (wr_hs_s && (beat_cnt_r == 2'd0)) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WDATA;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Downstream request register: loaded on accept, held until handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_req_valid_r <= 1'b0;
         mem_addr_r      <= 32'd0;
         mem_rnw_r       <= 1'b0;
         mem_len_r       <= 2'd0;
         mem_id_r        <= 2'd0;
      end else if (accept_s) begin
         mem_req_valid_r <= 1'b1;
         mem_addr_r      <= win_addr_s;
         mem_rnw_r       <= win_rnw_s;
         mem_len_r       <= win_len_s;
         mem_id_r        <= winner_s;
      end else if (req_hs_s) begin
         mem_req_valid_r <= 1'b0;
      end
   end

   // Round-robin pointer; a DCACHE priority grant does not advance it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_r <= 2'd0;
      end else if (accept_s && !pri_grant_s) begin
         rr_ptr_r <= 2'((int'(winner_s) + 1) % NUM_REQ);
      end
   end

   // Write beat counter: loaded with len on a write request handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt_r <= 2'd0;
      end else if (req_hs_s && !mem_rnw_r) begin
         beat_cnt_r <= mem_len_r;
      end else if (wr_hs_s && (beat_cnt_r != 2'd0)) begin
         beat_cnt_r <= beat_cnt_r - 2'd1;
      end
   end

   // Reads in flight; a same-cycle issue and final return cancel out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outst_r <= 3'd0;
      end else begin
         case ({rd_inc_s, rd_dec_s})
            2'b10:   outst_r <= (outst_r < 3'(MAX_OUTSTANDING)) ? outst_r + 3'd1 : outst_r;
            2'b01:   outst_r <= outst_r - 3'd1;
            default: outst_r <= outst_r;
         endcase
      end
   end

   assign mem_req_valid = mem_req_valid_r;
   assign mem_addr      = mem_addr_r;
   assign mem_rnw       = mem_rnw_r;
   assign mem_len       = mem_len_r;
   assign mem_id        = mem_id_r;

endmodule

// File: tb/tb_l1_bus_scheduler.sv
module tb_l1_bus_scheduler;

   localparam int N    = 4;
   localparam int MAXO = 4;
   localparam int T_A  = 200;    // all reads, always ready, fast returns
   localparam int T_B  = 1500;   // random mix
   localparam int T_C  = 3000;   // slow returns: saturate outstanding reads
   localparam int T_D  = 3400;   // requester 2 long writes, reset mid-burst
   localparam int T_END = 4000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_rnw, req_ready, wr_valid, wr_ready, rd_valid;
   logic [N*32-1:0] req_addr, wr_data;
   logic [N*2-1:0]  req_len;
   logic            mem_req_valid, mem_req_ready, mem_rnw;
   logic [31:0]     mem_addr, mem_wr_data, mem_rd_data, rd_data;
   logic [1:0]      mem_len, mem_id, mem_rd_id;
   logic            mem_wr_valid, mem_wr_ready, mem_rd_valid, mem_rd_last, rd_last;

   always #5 clk = ~clk;

   l1_bus_scheduler #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_rnw(req_rnw), .req_len(req_len),
      .req_ready(req_ready), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_rnw(mem_rnw), .mem_len(mem_len), .mem_id(mem_id),
      .mem_wr_valid(mem_wr_valid), .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_id(mem_rd_id),
      .mem_rd_last(mem_rd_last), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last)
   );

   typedef struct { logic [31:0] addr; logic rnw; logic [1:0] len; logic [1:0] id; } mreq_t;
   typedef struct { int id; int left; } job_t;

   int n_cmp = 0;
   int n_fail = 0;

   // requester shadow state (stimulus)
   bit          pend   [N];
   logic [31:0] p_addr [N];
   logic        p_rnw  [N];
   logic [1:0]  p_len  [N];
   logic [31:0] p_data [N][4];
   logic [31:0] wq[$];
   int          wq_id = 0;
   job_t        jobs[$];

   // reference model state
   int    m_phase = 0;   // 0 idle, 1 request presented, 2 write burst
   int    m_rr = 0, m_outst = 0, m_id = 0, m_len = 0, m_beats = 0;
   bit    m_rnw = 1'b0;
   mreq_t exp_q[$];
   logic [31:0] exp_wr_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: predicts grants, request timing, write forwarding, routing.
   initial begin : model
      bit [N-1:0]  elig;
      int          w, j;
      bit          pri, dec;
      logic [31:0] exp_rdy;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_wr_ready", 32'(wr_ready), 32'd0);
            chk("rst_mem_wr_valid", 32'(mem_wr_valid), 32'd0);
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            m_phase = 0; m_rr = 0; m_outst = 0; m_beats = 0;
            exp_q.delete();
            exp_wr_q.delete();
         end else begin
            for (int i = 0; i < N; i++)
               elig[i] = req_valid[i] && (!req_rnw[i] || (m_outst < MAXO));
            w = -1;
            pri = 1'b0;
            if (m_phase == 0) begin
               for (int k = 0; k < N; k++) begin
                  j = (m_rr + k) % N;
                  if (w < 0 && elig[j]) w = j;
               end
`ifdef L1_SCHED_DCACHE_PRIORITY_EN
               if (elig[0]) begin
                  w = 0;
                  pri = 1'b1;
               end
`endif
            end
            exp_rdy = (w >= 0) ? (32'd1 << w) : 32'd0;
            chk("req_ready", 32'(req_ready), exp_rdy);
            chk("mem_req_valid", 32'(mem_req_valid), 32'(m_phase == 1));
            if (m_phase == 2) begin
               chk("mem_wr_valid", 32'(mem_wr_valid), 32'(wr_valid[m_id]));
               chk("wr_ready", 32'(wr_ready), mem_wr_ready ? (32'd1 << m_id) : 32'd0);
            end else begin
               chk("mem_wr_valid_idle", 32'(mem_wr_valid), 32'd0);
               chk("wr_ready_idle", 32'(wr_ready), 32'd0);
            end
            if (mem_rd_valid && m_outst > 0) begin
               chk("rd_valid", 32'(rd_valid), 32'd1 << mem_rd_id);
               chk("rd_data", rd_data, mem_rd_data);
               chk("rd_last", 32'(rd_last), 32'(mem_rd_last));
            end else if (!mem_rd_valid) begin
               chk("rd_valid_quiet", 32'(rd_valid), 32'd0);
            end
            dec = mem_rd_valid && mem_rd_last && (m_outst > 0);
            case (m_phase)
               0: if (w >= 0) begin
                     exp_q.push_back('{addr: p_addr[w], rnw: p_rnw[w], len: p_len[w], id: 2'(w)});
                     if (!p_rnw[w])
                        for (int b = 0; b <= int'(p_len[w]); b++) exp_wr_q.push_back(p_data[w][b]);
                     m_id = w; m_rnw = p_rnw[w]; m_len = int'(p_len[w]);
                     m_phase = 1;
                     if (!pri) m_rr = (w + 1) % N;
                  end
               1: if (mem_req_ready) begin
                     if (m_rnw) begin
                        m_outst++;
                        m_phase = 0;
                     end else begin
                        m_phase = 2;
                        m_beats = m_len + 1;
                     end
                  end
               default: if (wr_valid[m_id] && mem_wr_ready) begin
                     m_beats--;
                     if (m_beats == 0) m_phase = 0;
                  end
            endcase
            if (dec) m_outst--;
         end
      end
   end

   // Monitor: compares downstream request fields and write beats against queues.
   initial begin : monitor
      mreq_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mem_req_valid) begin
               chk("mem_req_pending", {31'd0, exp_q.size() != 0}, 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q[0];
                  chk("mem_addr", mem_addr, e.addr);
                  chk("mem_rnw", 32'(mem_rnw), 32'(e.rnw));
                  chk("mem_len", 32'(mem_len), 32'(e.len));
                  chk("mem_id", 32'(mem_id), 32'(e.id));
                  if (mem_req_ready) void'(exp_q.pop_front());
               end
            end
            if (mem_wr_valid && mem_wr_ready) begin
               chk("wr_beat_pending", {31'd0, exp_wr_q.size() != 0}, 32'd1);
               if (exp_wr_q.size() != 0) chk("mem_wr_data", mem_wr_data, exp_wr_q.pop_front());
            end
         end
      end
   end

   // Driver: requesters, memory acceptor and read responder.
   initial begin : driver
      bit          acc [N];
      bit          wacc, mreq_hs, rbeat, hunted;
      logic        s_rnw;
      logic [1:0]  s_id, s_len;
      logic [31:0] tmp;
      int          mode, rst_cnt, rprob;
      rst_n = 1'b0; req_valid = '0; req_rnw = '0; req_addr = '0; req_len = '0;
      wr_valid = '0; wr_data = '0; mem_req_ready = 1'b0; mem_wr_ready = 1'b0;
      mem_rd_valid = 1'b0; mem_rd_data = 32'd0; mem_rd_id = 2'd0; mem_rd_last = 1'b0;
      hunted = 1'b0; rst_cnt = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; p_addr[i] = 32'd0; p_rnw[i] = 1'b1; p_len[i] = 2'd0;
      end
      for (int c = 0; c < T_END; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) acc[i] = rst_n && req_valid[i] && req_ready[i];
         wacc    = rst_n && (wq.size() > 0) && wr_valid[wq_id] && wr_ready[wq_id];
         mreq_hs = rst_n && mem_req_valid && mem_req_ready;
         s_rnw = mem_rnw; s_id = mem_id; s_len = mem_len;
         rbeat   = rst_n && mem_rd_valid && (jobs.size() > 0);
         @(posedge clk);
         #1;
         mode = (c < T_A) ? 0 : (c < T_B) ? 1 : (c < T_C) ? 2 : (c < T_D) ? 3 : 1;
         if (mode == 3 && !hunted && m_phase == 2 && m_len == 3 && m_beats == 2) begin
            hunted = 1'b1;
            rst_cnt = 2;
         end
         if (c == T_D) chk("rst_hunt_reached", 32'(hunted), 32'd1);
         if (c < 3 || rst_cnt > 0) begin
            rst_n = 1'b0;
            if (rst_cnt > 0) rst_cnt--;
            for (int i = 0; i < N; i++) pend[i] = 1'b0;
            wq.delete();
            jobs.delete();
            req_valid = N'($urandom); wr_valid = N'($urandom);
            mem_req_ready = 1'(($urandom % 2));
            mem_wr_ready = 1'(($urandom % 2));
            mem_rd_valid = 1'(($urandom % 2)); mem_rd_id = 2'($urandom % 4); mem_rd_last = 1'b1;
         end else begin
            rst_n = 1'b1;
            for (int i = 0; i < N; i++) if (acc[i]) begin
               pend[i] = 1'b0;
               if (!p_rnw[i]) begin
                  for (int b = 0; b <= int'(p_len[i]); b++) wq.push_back(p_data[i][b]);
                  wq_id = i;
               end
            end
            if (wacc) void'(wq.pop_front());
            if (rbeat) begin
               if (jobs[0].left == 0) void'(jobs.pop_front());
               else jobs[0].left--;
            end
            if (mreq_hs && s_rnw) jobs.push_back('{id: int'(s_id), left: int'(s_len)});
            for (int i = 0; i < N; i++) begin
               if (!pend[i] && !(wq.size() > 0 && wq_id == i) && (mode == 0 || ($urandom % 2) == 0)) begin
                  pend[i] = 1'b1;
                  tmp = $urandom;
                  p_addr[i] = tmp & 32'hFFFF_FFFC;
                  p_len[i] = 2'($urandom % 4);
                  if (mode == 0) p_rnw[i] = 1'b1;
                  else if (mode == 3) begin
                     p_rnw[i] = (i != 2);
                     if (i == 2) p_len[i] = 2'd3;
                  end else p_rnw[i] = 1'(($urandom % 2));
                  for (int b = 0; b < 4; b++) p_data[i][b] = $urandom;
               end
               req_valid[i] = pend[i] && (mode == 0 || ($urandom % 6) != 0);
               req_addr[i*32 +: 32] = p_addr[i];
               req_rnw[i] = p_rnw[i];
               req_len[i*2 +: 2] = p_len[i];
               wr_valid[i] = (wq.size() > 0 && wq_id == i) && (($urandom % 3) != 0);
               wr_data[i*32 +: 32] = (wq.size() > 0 && wq_id == i) ? wq[0] : $urandom;
            end
            mem_req_ready = (mode == 0) ? 1'b1 : (($urandom % 4) != 0);
            mem_wr_ready = 1'(($urandom % 2));
            rprob = (mode == 0) ? 1 : (mode == 2) ? 10 : 2;
            mem_rd_data = $urandom;
            if (jobs.size() > 0 && ($urandom % rprob) == 0) begin
               mem_rd_valid = 1'b1; mem_rd_id = 2'(jobs[0].id); mem_rd_last = (jobs[0].left == 0);
            end else if (jobs.size() == 0 && mode == 1 && ($urandom % 16) == 0) begin
               mem_rd_valid = 1'b1; mem_rd_id = 2'($urandom % 4); mem_rd_last = 1'b1;
            end else begin
               mem_rd_valid = 1'b0; mem_rd_id = 2'($urandom % 4); mem_rd_last = 1'(($urandom % 2));
            end
         end
      end
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
